// File: rtl/l1_arb_pkg.sv
// Shared types and default widths for the L1 instruction/data memory-port arbiter.
package l1_arb_pkg;

  localparam int unsigned L1_ADDR_W = 32;
  localparam int unsigned L1_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Also used as the bit index into the two-bit request/grant vectors.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/l1_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the side that did not win last time is granted.
module rr_arb2
  import l1_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  requester_t last_grant;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
    end
  end

  // Reset to D so the instruction side wins the very first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= REQ_D;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[REQ_D] ? REQ_D : REQ_I;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one downstream line port between the L1 I-cache and D-cache, one transaction at a time.
module l1_mem_arbiter
  import l1_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = L1_ADDR_W,
  parameter int unsigned LINE_W = L1_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  logic [1:0] req;
  logic [1:0] grant;
  logic       grant_en;

  always_comb begin
    req          = 2'b00;
    req[REQ_I]   = i_read;
    req[REQ_D]   = d_read | d_write;
  end

  // Grants happen only while idle; the picker's history advances on each one.
  assign grant_en = (state == IDLE);

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (grant_en),
    .grant  (grant)
  );

  // Op, address and write data are captured at grant so requester changes mid-transaction are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[REQ_I]) begin
            state      <= SERVE_I;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
            pmem_addr  <= i_addr;
            pmem_wdata <= '0;
          end else if (grant[REQ_D]) begin
            state      <= SERVE_D;
            pmem_read  <= ~d_write;
            pmem_write <= d_write;
            pmem_addr  <= d_addr;
            pmem_wdata <= d_write ? d_wdata : '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion is combinational so the requester sees it in the same cycle as pmem_resp.
  assign i_resp  = (state == SERVE_I) && pmem_resp;
  assign d_resp  = (state == SERVE_D) && pmem_resp;
  assign i_rdata = (state == SERVE_I) ? pmem_rdata : '0;
  assign d_rdata = (state == SERVE_D) ? pmem_rdata : '0;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(d_read && d_write))
        else $warning("l1_mem_arbiter: d_read and d_write both high, treating as write");
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: single reads, ties, write-back/refill interleave, reset abort, stray resp.
module tb_l1_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] line_a, line_b, line_c, pat_a5, pat_5a;

  l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a downstream completion in the current cycle and let it settle.
  task automatic drive_resp(input logic [LW-1:0] data);
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    #1;
  endtask

  initial begin
    line_a = {8{32'hDEAD_BEEF}};
    line_b = {8{32'h1234_5678}};
    line_c = {8{32'hCAFE_F00D}};
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};

    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    step(); step();
    chk("rst_pmem_read",  pmem_read,  0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr",  pmem_addr,  0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp",     i_resp,     0);
    chk("rst_d_resp",     d_resp,     0);
    rst = 1'b1;

    // Single I read, downstream answers in the third cycle.
    i_read = 1'b1; i_addr = 32'h0000_1000;
    step();
    chk("t1_c1_read", pmem_read, 1);
    chk("t1_c1_write", pmem_write, 0);
    chk("t1_c1_addr", pmem_addr, 32'h1000);
    chk("t1_c1_iresp", i_resp, 0);
    step();
    chk("t1_c2_read", pmem_read, 1);
    step();
    drive_resp(line_a);
    chk("t1_c3_read", pmem_read, 1);
    chk("t1_c3_iresp", i_resp, 1);
    chk("t1_c3_irdata", i_rdata, line_a);
    chk("t1_c3_dresp", d_resp, 0);
    chk("t1_c3_drdata", d_rdata, 0);
    step();
    pmem_resp = 1'b0; i_read = 1'b0;
    chk("t1_c4_read", pmem_read, 0);
    chk("t1_c4_iresp", i_resp, 0);

    // Fresh reset, then simultaneous I and D reads: I first, D after one idle cycle.
    rst = 1'b0; step(); rst = 1'b1;
    i_read = 1'b1; i_addr = 32'h1100; d_read = 1'b1; d_addr = 32'h2200;
    step();
    chk("t2_first_addr", pmem_addr, 32'h1100);
    chk("t2_first_read", pmem_read, 1);
    drive_resp(line_b);
    chk("t2_first_iresp", i_resp, 1);
    chk("t2_first_dresp", d_resp, 0);
    chk("t2_first_drdata", d_rdata, 0);
    step();
    pmem_resp = 1'b0; i_read = 1'b0;
    chk("t2_gap_read", pmem_read, 0);
    step();
    chk("t2_second_addr", pmem_addr, 32'h2200);
    chk("t2_second_read", pmem_read, 1);
    drive_resp(line_c);
    chk("t2_second_dresp", d_resp, 1);
    chk("t2_second_drdata", d_rdata, line_c);
    chk("t2_second_iresp", i_resp, 0);
    step();
    pmem_resp = 1'b0; d_read = 1'b0;

    // D was granted last, so the next tie goes to I.
    i_read = 1'b1; i_addr = 32'h1200; d_read = 1'b1; d_addr = 32'h2300;
    step();
    chk("t2_tie2_addr", pmem_addr, 32'h1200);
    drive_resp(line_a);
    chk("t2_tie2_iresp", i_resp, 1);
    step();
    pmem_resp = 1'b0; i_read = 1'b0;
    step();
    chk("t2_tie2_daddr", pmem_addr, 32'h2300);
    drive_resp(line_b);
    chk("t2_tie2_dresp", d_resp, 1);
    step();
    pmem_resp = 1'b0; d_read = 1'b0;

    // D write-back, I read pending throughout, then D refill.
    d_write = 1'b1; d_addr = 32'h2000; d_wdata = pat_a5;
    step();
    i_read = 1'b1; i_addr = 32'h3000;
    chk("t3_wb_write", pmem_write, 1);
    chk("t3_wb_read", pmem_read, 0);
    chk("t3_wb_addr", pmem_addr, 32'h2000);
    chk("t3_wb_wdata", pmem_wdata, pat_a5);
    step();
    drive_resp(line_c);
    chk("t3_wb_dresp", d_resp, 1);
    chk("t3_wb_iresp", i_resp, 0);
    step();
    pmem_resp = 1'b0;
    d_write = 1'b0; d_read = 1'b1; d_addr = 32'h2040; d_wdata = '0;
    chk("t3_gap1_read", pmem_read, 0);
    chk("t3_gap1_write", pmem_write, 0);
    step();
    chk("t3_i_addr", pmem_addr, 32'h3000);
    chk("t3_i_read", pmem_read, 1);
    drive_resp(line_a);
    chk("t3_i_resp", i_resp, 1);
    chk("t3_i_rdata", i_rdata, line_a);
    step();
    pmem_resp = 1'b0; i_read = 1'b0;
    step();
    chk("t3_refill_addr", pmem_addr, 32'h2040);
    chk("t3_refill_read", pmem_read, 1);
    chk("t3_refill_write", pmem_write, 0);
    drive_resp(line_b);
    chk("t3_refill_drdata", d_rdata, line_b);
    step();
    pmem_resp = 1'b0; d_read = 1'b0;

    // Illegal read+write from D: the write wins.
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h4000; d_wdata = pat_5a;
    step();
    chk("t4_write", pmem_write, 1);
    chk("t4_read", pmem_read, 0);
    chk("t4_wdata", pmem_wdata, pat_5a);
    drive_resp(line_c);
    chk("t4_dresp", d_resp, 1);
    step();
    pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;

    // Reset while serving D, then release with both requesters pending.
    d_read = 1'b1; d_addr = 32'h5000;
    step();
    chk("t5_serve_d", pmem_read, 1);
    i_read = 1'b1; i_addr = 32'h6000;
    rst = 1'b0;
    #1;
    chk("t5_rst_read", pmem_read, 0);
    chk("t5_rst_addr", pmem_addr, 0);
    drive_resp(line_a);
    chk("t5_rst_dresp", d_resp, 0);
    chk("t5_rst_iresp", i_resp, 0);
    pmem_resp = 1'b0;
    step();
    chk("t5_rst_hold_read", pmem_read, 0);
    rst = 1'b1;
    step();
    chk("t5_after_addr", pmem_addr, 32'h6000);
    chk("t5_after_read", pmem_read, 1);
    drive_resp(line_b);
    chk("t5_after_iresp", i_resp, 1);
    step();
    pmem_resp = 1'b0; i_read = 1'b0;
    step();
    chk("t5_d_addr", pmem_addr, 32'h5000);
    drive_resp(line_c);
    chk("t5_d_resp", d_resp, 1);
    step();
    pmem_resp = 1'b0; d_read = 1'b0;

    // Stray completion while idle.
    step();
    drive_resp(line_a);
    chk("t6_iresp", i_resp, 0);
    chk("t6_dresp", d_resp, 0);
    chk("t6_irdata", i_rdata, 0);
    step();
    pmem_resp = 1'b0;
    chk("t6_read", pmem_read, 0);
    i_read = 1'b1; i_addr = 32'h7000;
    step();
    chk("t6_next_addr", pmem_addr, 32'h7000);
    chk("t6_next_read", pmem_read, 1);
    drive_resp(line_b);
    chk("t6_next_iresp", i_resp, 1);
    step();
    pmem_resp = 1'b0; i_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Two-requester arbiter that shares the single physical-memory port between the L1 instruction cache (read-only) and the L1 data cache (read/write). It sits between the two L1 cache controllers and the next memory level (L2 or main memory). Each transaction is one full cache line. Simultaneous requests are resolved round-robin. Exactly one transaction is outstanding downstream at any time.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line data returned to I-cache
- i_resp  out  1  I-cache transaction complete, one-cycle pulse
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line write-back request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write-back data
- d_rdata  out  LINE_W  line data returned to D-cache
- d_resp  out  1  D-cache transaction complete, one-cycle pulse
- pmem_read  out  1  downstream read, held until pmem_resp
- pmem_write  out  1  downstream write, held until pmem_resp
- pmem_addr  out  ADDR_W  downstream address
- pmem_wdata  out  LINE_W  downstream write data
- pmem_rdata  in  LINE_W  downstream read data, valid with pmem_resp
- pmem_resp  in  1  downstream completion

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Any request present: pick a winner, latch its op/addr/wdata into internal registers, and go to SERVE_I or SERVE_D.
  - No request: stay in IDLE.
- Round-robin:
  - last_grant register, reset value D, so I wins the first tie.
  - On a tie the winner is the side not equal to last_grant.
  - last_grant updates on every grant, contended or not.
- SERVE_x:
  - Drive pmem_read/pmem_write/pmem_addr/pmem_wdata from the latched registers.
  - On pmem_resp: pulse x_resp, forward pmem_rdata to x_rdata, and return to IDLE.
- D-cache op: d_write and d_read both high is illegal. Write wins and a simulation assertion fires.
- Requests may not be withdrawn before resp. The arbiter ignores input changes during SERVE because it uses the latched values.
- pmem_resp in IDLE is ignored, with no resp pulse.
- The non-granted requester sees x_resp=0. Its x_rdata is don't-care; drive 0.

## Timing
- Reset (async assert, sync release): state=IDLE, last_grant=D, latched regs=0. All outputs are 0.
- Request sampled in IDLE at cycle 0. pmem_read/write assert from cycle 1.
- x_resp is combinational from pmem_resp in the same cycle. The state is IDLE the following cycle.
- Minimum turnaround is one IDLE cycle between downstream transactions. pmem_read/write are low that cycle.
- Uncontended latency = downstream latency + 1 cycle.
- A request arriving while the other side is served waits. It is granted in the next IDLE cycle and always wins, because last_grant = other side.
- Write-back then refill from the D-cache consists of two consecutive D transactions. An I request pending during the write-back is granted between them.
- Reset mid-SERVE aborts immediately. Outputs drop to 0 and no resp is issued. The downstream must tolerate the dropped request.

## Structure
- Package l1_arb_pkg holds:
  - the arb_state_t enum (IDLE, SERVE_I, SERVE_D)
  - the requester_t enum (REQ_I, REQ_D)
  - the LINE_W/ADDR_W defaults
- Sub-module rr_arb2: a 2-way round-robin picker with req[1:0] in, last_grant register, grant one-hot out, and an update enable. The FSM and datapath muxing stay in l1_mem_arbiter.

## Test plan
- Single I read at i_addr=0x0000_1000. Memory responds after 3 cycles -> pmem_read high cycles 1–3 with pmem_addr=0x1000. i_resp pulses in cycle 3 with i_rdata=the line pattern. d_resp stays 0.
- I and D reads asserted in the same cycle after reset -> I served first, then D after one IDLE cycle. The next tie goes to I again only if D was granted last.
- D write-back (d_write, d_addr=0x2000, d_wdata=0xA5…A5) followed by d_read 0x2040, with i_read 0x3000 pending throughout -> order is D write, I read, D read. pmem_wdata=0xA5…A5 during the write.
- d_read and d_write both high -> a write is issued and the assertion fires.
- Reset asserted (rst=0) mid-SERVE_D, then released with i_read pending -> all outputs are 0 during reset, no d_resp, and the I transaction is granted first after release.
- Stray pmem_resp in IDLE -> no i_resp or d_resp, and the state remains IDLE.
